image_loader: RTL

- Boot-time loader upstream of CoreTop.
- Accepts a byte stream of the 3072-word program image and writes words 0..1023 into the instruction cache RAM.
- Zero-fills the tohost/fromhost region, words 1024..2047.
- Writes words 2048..3071 into the byte-laned data cache RAM.
- Holds the core in reset until the image is fully written, then releases it.

---
 rtl/image_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/image_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, fills the
// instruction RAM, zero-fills the host window, then fills data RAM and releases the core.
module image_loader #(
  parameter int IRAM_WORDS  = 1024,
  parameter int HOST_WORDS  = 1024,
  parameter int DRAM_WORDS  = 1024,
  parameter int TOTAL_WORDS = IRAM_WORDS + HOST_WORDS + DRAM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        iram_we,
  output logic [9:0]  iram_addr,
  output logic [31:0] iram_wdata,
  output logic [3:0]  dram_we,
  output logic [10:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(TOTAL_WORDS);
  localparam logic [CNT_W-1:0] HOST_BASE = CNT_W'(IRAM_WORDS);
  localparam logic [CNT_W-1:0] DATA_BASE = CNT_W'(IRAM_WORDS + HOST_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL_WORDS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_p0;
  logic [31:0]      word_p0;
  logic             xfer;

  assign xfer    = s_valid & s_ready;
  assign word_p0 = {s_data, asm_p0};

  // Stage p0: lower three bytes are held; the fourth byte joins them on the final handshake.
  always_ff @(posedge clk) begin
    if (xfer) begin
      case (byte_cnt)
        2'd0:    asm_p0[7:0]   <= s_data;
        2'd1:    asm_p0[15:8]  <= s_data;
        2'd2:    asm_p0[23:16] <= s_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      byte_cnt   <= 2'd0;
      s_ready    <= 1'b0;
      iram_we    <= 1'b0;
      iram_addr  <= '0;
      iram_wdata <= '0;
      dram_we    <= 4'h0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      iram_we <= 1'b0;
      dram_we <= 4'h0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RECV;
            word_cnt <= '0;
            byte_cnt <= 2'd0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            core_rst <= 1'b1;
          end
        end
        ST_RECV: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Stage p1: the write is registered here so the strobe lands one cycle after the 4th byte.
              state   <= ST_WRITE;
              s_ready <= 1'b0;
              if (word_cnt < HOST_BASE) begin
                iram_we    <= 1'b1;
                iram_addr  <= 10'(word_cnt);
                iram_wdata <= word_p0;
              end else begin
                dram_we    <= 4'hF;
                dram_addr  <= 11'(word_cnt - HOST_BASE);
                dram_wdata <= (word_cnt < DATA_BASE) ? 32'h0 : word_p0;
              end
            end
          end
        end
        ST_WRITE: begin
          if (word_cnt == LAST_WORD) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b0;
          end else begin
            state    <= ST_RECV;
            word_cnt <= word_cnt + 1'b1;
            s_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
